cmos_nvram_port: RTL and testbench

- HPS-side access port to the Williams-2 1K×4 CMOS RAM, which holds high scores and settings.
- Serves ioctl upload reads (NVRAM save) by driving ioctl_din and ioctl_wait.
- Serves ioctl download writes (NVRAM restore) for the NVRAM index.
- Sits between hps_io and the williams2 CMOS RAM port. Accesses the RAM only in CPU-free slots flagged by the core.

---
 rtl/cmos_nvram_port.sv | 124 ++++++++++++
 tb/tb_cmos_nvram_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_nvram_port.sv
// HPS ioctl port onto the Williams-2 1Kx4 CMOS RAM: NVRAM save (upload reads)
// and restore (download writes), using only CPU-free mem_slot cycles.
module cmos_nvram_port #(
  parameter logic [7:0] NVRAM_INDEX = 8'd4,
  parameter int         ADDR_W      = 10
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [23:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              mem_slot,
  output logic              cmos_sel,
  output logic [ADDR_W-1:0] cmos_addr,
  output logic              cmos_we,
  output logic [3:0]        cmos_wdata,
  input  logic [3:0]        cmos_rdata,
  input  logic              cpu_cmos_we,
  output logic              nvram_dirty
);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nx;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        data_q;

  logic index_hit, up_act, dn_act, up_only, dn_only, in_range;
  logic start_rd, start_wr, oor_rd, dirty_clr;
  logic unused_dout;

  assign index_hit = (ioctl_index == NVRAM_INDEX);
  assign up_act    = ioctl_upload   & index_hit;
  assign dn_act    = ioctl_download & index_hit;
  // Simultaneous upload and download is treated as a host error: serve neither.
  assign up_only   = up_act & ~dn_act;
  assign dn_only   = dn_act & ~up_act;
  assign in_range  = (ioctl_addr[23:ADDR_W] == '0);

  assign start_rd  = (state == IDLE) & up_only & ioctl_rd & in_range;
  assign start_wr  = (state == IDLE) & dn_only & ioctl_wr & in_range;
  assign oor_rd    = (state == IDLE) & up_only & ioctl_rd & ~in_range;

  assign unused_dout = &{1'b0, ioctl_dout[7:4]};

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start_rd || start_wr) state_nx = WAIT_SLOT;
      WAIT_SLOT: if (mem_slot) state_nx = op_wr ? DONE : READ;
      READ:      state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // The CMOS port is driven only during the granted slot; zero otherwise so
  // the RAM-side mux never sees stale address or data.
  always_comb begin
    cmos_sel   = 1'b0;
    cmos_we    = 1'b0;
    cmos_addr  = '0;
    cmos_wdata = 4'h0;
    if (state == WAIT_SLOT && mem_slot) begin
      cmos_sel  = 1'b1;
      cmos_addr = addr_q;
      if (op_wr) begin
        cmos_we    = 1'b1;
        cmos_wdata = data_q;
      end
    end
  end

  assign dirty_clr = ((state == READ) & up_act & (addr_q == LAST_ADDR)) |
                     (cmos_we & dn_act & (addr_q == LAST_ADDR));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_wr       <= 1'b0;
      addr_q      <= '0;
      data_q      <= 4'h0;
      ioctl_din   <= 8'h00;
      ioctl_wait  <= 1'b0;
      nvram_dirty <= 1'b0;
    end else begin
      state <= state_nx;

      if (start_rd || start_wr) begin
        addr_q     <= ioctl_addr[ADDR_W-1:0];
        op_wr      <= start_wr;
        ioctl_wait <= 1'b1;
        if (start_wr) data_q <= ioctl_dout[3:0];
      end

      if (oor_rd) ioctl_din <= 8'hFF;

      // Wait drops together with the read data capture so the HPS sees both
      // on the same cycle; a write releases wait from DONE.
      if (state == READ) begin
        ioctl_din  <= {4'hF, cmos_rdata};
        ioctl_wait <= 1'b0;
      end
      if (state == DONE) ioctl_wait <= 1'b0;

      if (cpu_cmos_we)    nvram_dirty <= 1'b1;
      else if (dirty_clr) nvram_dirty <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmos_nvram_port.sv
// Directed-plus-random bench for cmos_nvram_port with a behavioural CMOS RAM
// and a nibble-array reference of what the NVRAM should contain.
module tb_cmos_nvram_port;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  ioctl_index;
  logic        ioctl_upload, ioctl_download;
  logic [23:0] ioctl_addr;
  logic        ioctl_rd, ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_slot;
  logic        cmos_sel;
  logic [9:0]  cmos_addr;
  logic        cmos_we;
  logic [3:0]  cmos_wdata;
  logic [3:0]  cmos_rdata;
  logic        cpu_cmos_we;
  logic        nvram_dirty;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] ram     [1024];
  logic [3:0] ref_mem [1024];

  always #5 clk_sys = ~clk_sys;

  cmos_nvram_port #(.NVRAM_INDEX(8'd4), .ADDR_W(10)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_index    (ioctl_index),
    .ioctl_upload   (ioctl_upload),
    .ioctl_download (ioctl_download),
    .ioctl_addr     (ioctl_addr),
    .ioctl_rd       (ioctl_rd),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_din      (ioctl_din),
    .ioctl_wait     (ioctl_wait),
    .mem_slot       (mem_slot),
    .cmos_sel       (cmos_sel),
    .cmos_addr      (cmos_addr),
    .cmos_we        (cmos_we),
    .cmos_wdata     (cmos_wdata),
    .cmos_rdata     (cmos_rdata),
    .cpu_cmos_we    (cpu_cmos_we),
    .nvram_dirty    (nvram_dirty)
  );

  // CMOS RAM: synchronous write, read data one cycle after the address.
  always @(posedge clk_sys) begin
    if (cmos_sel && cmos_we) ram[cmos_addr] <= cmos_wdata;
    cmos_rdata <= ram[cmos_addr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total_cnt++;
    assert (obs === want) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One HPS access; the slot arrives `delay` cycles after the strobe (>=1).
  task automatic access(input bit is_wr, input logic [9:0] addr, input logic [7:0] dout,
                        input int delay, input bit cpu_we_in_read, input bit drop_mode);
    int early_bad;
    early_bad = 0;
    step();
    ioctl_addr = {14'h0, addr};
    if (is_wr) begin
      ioctl_wr   = 1'b1;
      ioctl_dout = dout;
    end else begin
      ioctl_rd = 1'b1;
    end
    for (int k = 1; k < delay; k++) begin
      step();
      ioctl_rd = 1'b0;
      ioctl_wr = 1'b0;
      if (drop_mode) begin
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
      end
      @(negedge clk_sys);
      if (cmos_sel || !ioctl_wait) early_bad++;
    end
    step();
    ioctl_rd = 1'b0;
    ioctl_wr = 1'b0;
    mem_slot = 1'b1;
    @(negedge clk_sys);
    check("slot_sel", cmos_sel, 1);
    check("slot_addr", cmos_addr, addr);
    check("slot_we", cmos_we, is_wr);
    if (is_wr) check("slot_wdata", cmos_wdata, dout[3:0]);
    check("slot_wait", ioctl_wait, 1);
    step();
    mem_slot    = 1'b0;
    cpu_cmos_we = cpu_we_in_read;
    @(negedge clk_sys);
    check("post_slot_sel", cmos_sel, 0);
    check("post_slot_wait", ioctl_wait, 1);
    step();
    cpu_cmos_we = 1'b0;
    @(negedge clk_sys);
    check("wait_low", ioctl_wait, 0);
    if (is_wr) ref_mem[addr] = dout[3:0];
    else       check("din", ioctl_din, {4'hF, ref_mem[addr]});
    if (delay > 1) check("early_access", early_bad, 0);
    step();
  endtask

  task automatic set_mode(input logic [7:0] idx, input bit up, input bit dn);
    ioctl_index    = idx;
    ioctl_upload   = up;
    ioctl_download = dn;
  endtask

  initial begin
    logic [9:0] a;
    logic [7:0] d;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 4'($urandom);
      ref_mem[i] = ram[i];
    end
    reset = 1'b1;
    set_mode(8'd0, 1'b0, 1'b0);
    ioctl_addr = '0; ioctl_rd = 1'b0; ioctl_wr = 1'b0; ioctl_dout = '0;
    mem_slot = 1'b0; cpu_cmos_we = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_din", ioctl_din, 8'h00);
    check("rst_wait", ioctl_wait, 0);
    check("rst_sel", cmos_sel, 0);
    check("rst_we", cmos_we, 0);
    check("rst_addr", cmos_addr, 0);
    check("rst_wdata", cmos_wdata, 0);
    check("rst_dirty", nvram_dirty, 0);
    step();
    reset = 1'b0;

    // Upload read with a one-cycle slot.
    ram[10'h3A5] = 4'h7; ref_mem[10'h3A5] = 4'h7;
    set_mode(8'd4, 1'b1, 1'b0);
    access(1'b0, 10'h3A5, 8'h00, 1, 1'b0, 1'b0);
    check("din_3a5", ioctl_din, 8'hF7);

    // Slot held off for 40 cycles.
    access(1'b0, 10'h010, 8'h00, 40, 1'b0, 1'b0);

    // Download write then readback.
    set_mode(8'd4, 1'b0, 1'b1);
    access(1'b1, 10'h123, 8'hC9, 1, 1'b0, 1'b0);
    check("ram_123", ram[10'h123], 4'h9);
    set_mode(8'd4, 1'b1, 1'b0);
    access(1'b0, 10'h123, 8'h00, 1, 1'b0, 1'b0);
    check("din_123", ioctl_din, 8'hF9);

    // Random writes and reads with random slot delays.
    for (int n = 0; n < 12; n++) begin
      a = 10'($urandom);
      d = 8'($urandom);
      set_mode(8'd4, 1'b0, 1'b1);
      access(1'b1, a, d, int'($urandom_range(1, 6)), 1'b0, 1'b0);
      a = 10'($urandom);
      set_mode(8'd4, 1'b1, 1'b0);
      access(1'b0, a, 8'h00, int'($urandom_range(1, 6)), 1'b0, 1'b0);
    end

    // Upload dropped mid-op: the pending read still completes.
    set_mode(8'd4, 1'b1, 1'b0);
    access(1'b0, 10'h2C4, 8'h00, 5, 1'b0, 1'b1);
    set_mode(8'd4, 1'b1, 1'b0);

    // Out-of-range read.
    step();
    ioctl_addr = 24'h000400;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("oor_din", ioctl_din, 8'hFF);
    check("oor_wait", ioctl_wait, 0);
    check("oor_sel", cmos_sel, 0);

    // Both directions active: strobe ignored, din untouched.
    set_mode(8'd4, 1'b1, 1'b1);
    step();
    ioctl_addr = 24'h000020;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    mem_slot = 1'b1;
    @(negedge clk_sys);
    check("both_wait", ioctl_wait, 0);
    check("both_sel", cmos_sel, 0);
    check("both_din", ioctl_din, 8'hFF);
    step();
    mem_slot = 1'b0;

    // Wrong index write.
    set_mode(8'd0, 1'b0, 1'b1);
    step();
    ioctl_addr = 24'h000050;
    ioctl_dout = {4'h0, ~ref_mem[10'h050]};
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr = 1'b0;
    mem_slot = 1'b1;
    @(negedge clk_sys);
    check("idx_sel", cmos_sel, 0);
    check("idx_wait", ioctl_wait, 0);
    step();
    mem_slot = 1'b0;
    set_mode(8'd4, 1'b1, 1'b0);
    access(1'b0, 10'h050, 8'h00, 1, 1'b0, 1'b0);

    // Dirty tracking across a full save.
    step();
    cpu_cmos_we = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
    @(negedge clk_sys);
    check("dirty_set", nvram_dirty, 1);
    for (int i = 0; i < 1023; i++)
      access(1'b0, 10'(i), 8'h00, int'($urandom_range(1, 3)), 1'b0, 1'b0);
    check("dirty_before_last", nvram_dirty, 1);
    access(1'b0, 10'h3FF, 8'h00, 2, 1'b0, 1'b0);
    check("dirty_cleared", nvram_dirty, 0);

    // CPU write coinciding with the final READ keeps the flag set.
    access(1'b0, 10'h3FF, 8'h00, 1, 1'b1, 1'b0);
    check("dirty_set_wins", nvram_dirty, 1);

    // Restore ending at the last address clears the flag.
    set_mode(8'd4, 1'b0, 1'b1);
    access(1'b1, 10'h3FF, 8'h3C, 1, 1'b0, 1'b0);
    check("dirty_dl_clear", nvram_dirty, 0);

    // Reset with a write pending in WAIT_SLOT.
    step();
    ioctl_addr = 24'h000077;
    ioctl_dout = {4'h0, ~ref_mem[10'h077]};
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check("pend_wait", ioctl_wait, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_wait", ioctl_wait, 0);
    step();
    reset = 1'b0;
    step();
    mem_slot = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_sel", cmos_sel, 0);
    check("rst_mid_we", cmos_we, 0);
    step();
    mem_slot = 1'b0;
    check("rst_mid_ram", ram[10'h077], ref_mem[10'h077]);
    set_mode(8'd4, 1'b1, 1'b0);
    access(1'b0, 10'h077, 8'h00, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
